// File: rtl/spawn_scheduler.sv
// Round-robin spawn arbiter for the obstacle and collectible controllers.
// Grants one spawn at a time, enforces a tick gap, and hands out clamped amplitude and level-based speed.
module spawn_scheduler #(
    parameter int          GAP_TICKS   = 8,
    parameter logic [9:0]  AMP_MAX     = 10'd200,
    parameter logic [9:0]  SPEED_BASE  = 10'd5,
    parameter logic [9:0]  SPEED_MAX   = 10'd12,
    parameter int          LEVEL_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_en,
    input  logic        enable,
    input  logic        req_obst,
    input  logic        req_green,
    input  logic [9:0]  rand_in,
    input  logic [7:0]  bank_level,
    output logic        grant_obst,
    output logic        grant_green,
    output logic [9:0]  spawn_amp,
    output logic [9:0]  spawn_speed,
    output logic        busy
);

    localparam int CNT_W = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   gap_cnt;
    logic               pend_o;
    logic               pend_g;
    logic               last_green;
    logic               arb;
    logic               win_obst;
    logic               clr_o;
    logic               clr_g;

    function automatic logic [9:0] clamp_amp(input logic [9:0] amp);
        return (amp > AMP_MAX) ? AMP_MAX : amp;
    endfunction

    function automatic logic [9:0] calc_speed(input logic [7:0] level);
        logic [9:0] sum;
        sum = SPEED_BASE + ({2'b00, level} >> LEVEL_SHIFT);
        return (sum > SPEED_MAX) ? SPEED_MAX : sum;
    endfunction

    // Obstacle wins when it is the only one pending, or on a tie when green went last.
    always_comb begin
        arb      = (state == S_IDLE) && game_en && (pend_o || pend_g);
        win_obst = pend_o && (!pend_g || last_green);
        clr_o    = arb && win_obst;
        clr_g    = arb && !win_obst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            gap_cnt     <= '0;
            pend_o      <= 1'b0;
            pend_g      <= 1'b0;
            last_green  <= 1'b1;
            grant_obst  <= 1'b0;
            grant_green <= 1'b0;
            spawn_amp   <= '0;
            spawn_speed <= SPEED_BASE;
            busy        <= 1'b0;
        end else if (!enable) begin
            state       <= S_IDLE;
            gap_cnt     <= '0;
            pend_o      <= 1'b0;
            pend_g      <= 1'b0;
            grant_obst  <= 1'b0;
            grant_green <= 1'b0;
            busy        <= 1'b0;
        end else begin
            grant_obst  <= 1'b0;
            grant_green <= 1'b0;
            // A new request in the same cycle as the clear keeps the bit set.
            pend_o      <= (pend_o && !clr_o) || req_obst;
            pend_g      <= (pend_g && !clr_g) || req_green;
            case (state)
                S_IDLE: begin
                    if (arb) begin
                        grant_obst  <= win_obst;
                        grant_green <= !win_obst;
                        last_green  <= !win_obst;
                        spawn_amp   <= clamp_amp(rand_in);
                        spawn_speed <= calc_speed(bank_level);
                        gap_cnt     <= CNT_W'(GAP_TICKS);
                        state       <= S_GRANT;
                        busy        <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (GAP_TICKS == 0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_GAP;
                        busy  <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (game_en) begin
                        if (gap_cnt <= CNT_W'(1)) begin
                            gap_cnt <= '0;
                            state   <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler: directed vector table, hand sequences for corner cases,
// and randomized traffic against a tick-counting reference model.
module tb_spawn_scheduler;

    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       game_en = 1'b0;
    logic       enable = 1'b0;
    logic       req_obst = 1'b0;
    logic       req_green = 1'b0;
    logic [9:0] rand_in = '0;
    logic [7:0] bank_level = '0;
    logic       grant_obst;
    logic       grant_green;
    logic [9:0] spawn_amp;
    logic [9:0] spawn_speed;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: pending flags, who went last, ticks seen since the grant pulse.
    int m_po, m_pg, m_last_g, m_ticks, m_gcyc;
    int m_go, m_gg, m_amp, m_spd, m_busy;

    typedef struct {
        int e, ge, ro, rg, rnd, lv;
        int go, gg, amp, spd, bsy;
    } vec_t;

    localparam int NV = 16;
    vec_t tv[NV];

    spawn_scheduler #(.GAP_TICKS(GAP)) dut (
        .clk(clk), .rst(rst), .game_en(game_en), .enable(enable),
        .req_obst(req_obst), .req_green(req_green), .rand_in(rand_in),
        .bank_level(bank_level), .grant_obst(grant_obst), .grant_green(grant_green),
        .spawn_amp(spawn_amp), .spawn_speed(spawn_speed), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_po = 0; m_pg = 0; m_last_g = 1; m_ticks = GAP; m_gcyc = 0;
        m_go = 0; m_gg = 0; m_amp = 0; m_spd = 5; m_busy = 0;
    endtask

    task automatic model_step(input int e, input int ge, input int ro, input int rg,
                              input int rnd, input int lv);
        int gnow;
        int wo;
        gnow = 0;
        m_go = 0;
        m_gg = 0;
        if (e == 0) begin
            m_po = 0; m_pg = 0; m_ticks = GAP; m_gcyc = 0; m_busy = 0;
            return;
        end
        if (m_gcyc == 0 && ge != 0 && m_ticks >= GAP && (m_po != 0 || m_pg != 0)) begin
            if (m_po != 0 && m_pg != 0) wo = m_last_g;
            else                        wo = m_po;
            gnow = 1;
            m_go = wo;
            m_gg = 1 - wo;
            m_last_g = 1 - wo;
            m_amp = (rnd > 200) ? 200 : rnd;
            m_spd = (5 + lv / 4 > 12) ? 12 : 5 + lv / 4;
            if (wo != 0) m_po = 0; else m_pg = 0;
        end
        if (ro != 0) m_po = 1;
        if (rg != 0) m_pg = 1;
        if (gnow != 0) begin
            m_ticks = 0;
        end else if (m_gcyc == 0 && ge != 0 && m_ticks < GAP) begin
            m_ticks++;
        end
        m_gcyc = gnow;
        m_busy = (gnow != 0 || m_ticks < GAP) ? 1 : 0;
    endtask

    task automatic apply(input int e, input int ge, input int ro, input int rg,
                         input int rnd, input int lv);
        enable     = (e != 0);
        game_en    = (ge != 0);
        req_obst   = (ro != 0);
        req_green  = (rg != 0);
        rand_in    = 10'(rnd);
        bank_level = 8'(lv);
        @(posedge clk);
        #1;
        model_step(e, ge, ro, rg, rnd, lv);
        chk("grant_obst", int'(grant_obst), m_go);
        chk("grant_green", int'(grant_green), m_gg);
        chk("spawn_amp", int'(spawn_amp), m_amp);
        chk("spawn_speed", int'(spawn_speed), m_spd);
        chk("busy", int'(busy), m_busy);
        game_en   = 1'b0;
        req_obst  = 1'b0;
        req_green = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        enable = 1'b1;
        game_en = 1'b0;
        req_obst = 1'b0;
        req_green = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant_obst", int'(grant_obst), 0);
        chk("rst_grant_green", int'(grant_green), 0);
        chk("rst_spawn_amp", int'(spawn_amp), 0);
        chk("rst_spawn_speed", int'(spawn_speed), 5);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
    endtask

    initial begin
        int grants;
        int lv;
        tv = '{
            '{1,0,1,0,150,  0, 0,0,  0,5,0},
            '{1,1,0,0,150,  0, 1,0,150,5,1},
            '{1,0,0,0,150,  0, 0,0,150,5,1},
            '{1,0,1,1,300, 12, 0,0,150,5,1},
            '{1,1,0,0,300, 12, 0,0,150,5,1},
            '{1,1,0,0,300, 12, 0,0,150,5,1},
            '{1,1,0,0,300, 12, 0,0,150,5,1},
            '{1,1,0,0,300, 12, 0,0,150,5,1},
            '{1,1,0,0,300, 12, 0,0,150,5,1},
            '{1,1,0,0,300, 12, 0,0,150,5,1},
            '{1,1,0,0,300, 12, 0,0,150,5,1},
            '{1,1,0,0,300, 12, 0,0,150,5,0},
            '{1,1,0,0,300, 12, 0,1,200,8,1},
            '{1,0,0,0,300,255, 0,0,200,8,1},
            '{0,0,0,0,300,255, 0,0,200,8,0},
            '{1,1,0,0,300,255, 0,0,200,8,0}
        };

        do_reset();
        for (int i = 0; i < NV; i++) begin
            apply(tv[i].e, tv[i].ge, tv[i].ro, tv[i].rg, tv[i].rnd, tv[i].lv);
            chk($sformatf("tbl%0d_go", i), int'(grant_obst), tv[i].go);
            chk($sformatf("tbl%0d_gg", i), int'(grant_green), tv[i].gg);
            chk($sformatf("tbl%0d_amp", i), int'(spawn_amp), tv[i].amp);
            chk($sformatf("tbl%0d_spd", i), int'(spawn_speed), tv[i].spd);
            chk($sformatf("tbl%0d_busy", i), int'(busy), tv[i].bsy);
        end

        // Tie right after reset goes to obstacle; green follows only after the gap; saturated speed.
        do_reset();
        apply(1, 0, 1, 1, 50, 255);
        apply(1, 1, 0, 0, 50, 255);
        chk("tie_first_obst", int'(grant_obst), 1);
        chk("sat_speed", int'(spawn_speed), 12);
        grants = 0;
        apply(1, 0, 0, 0, 50, 255);
        for (int t = 0; t < GAP; t++) begin
            apply(1, 1, 0, 0, 60, 255);
            grants += int'(grant_obst) + int'(grant_green);
            apply(1, 0, 0, 0, 60, 255);
            grants += int'(grant_obst) + int'(grant_green);
        end
        chk("no_grant_in_gap", grants, 0);
        apply(1, 1, 0, 0, 60, 255);
        chk("green_after_gap", int'(grant_green), 1);

        // Request landing in the cycle of its own grant stays pending.
        do_reset();
        apply(1, 0, 0, 1, 90, 8);
        apply(1, 1, 0, 0, 90, 8);
        chk("green_grant1", int'(grant_green), 1);
        apply(1, 0, 0, 1, 90, 8);
        grants = 0;
        for (int t = 0; t < GAP + 2; t++) begin
            apply(1, 1, 0, 0, 90, 8);
            grants += int'(grant_green);
            apply(1, 0, 0, 0, 90, 8);
        end
        chk("green_regrant", grants, 1);

        // Enable drop in GAP with obstacle pending, then no grant without a new request.
        do_reset();
        apply(1, 0, 1, 0, 10, 0);
        apply(1, 1, 1, 0, 10, 0);
        apply(1, 1, 0, 0, 10, 0);
        apply(0, 0, 0, 0, 10, 0);
        chk("en_drop_busy", int'(busy), 0);
        grants = 0;
        for (int t = 0; t < GAP + 4; t++) begin
            apply(1, 1, 0, 0, 10, 0);
            grants += int'(grant_obst) + int'(grant_green);
        end
        chk("no_grant_after_reenable", grants, 0);

        // Reset asserted while the grant pulse is out.
        do_reset();
        apply(1, 0, 1, 0, 77, 40);
        apply(1, 1, 0, 0, 77, 40);
        chk("pre_rst_grant", int'(grant_obst), 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_grant_obst", int'(grant_obst), 0);
        chk("rst_mid_amp", int'(spawn_amp), 0);
        chk("rst_mid_speed", int'(spawn_speed), 5);
        chk("rst_mid_busy", int'(busy), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(1, 1, 0, 0, 77, 40);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            lv = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
            apply(($urandom_range(0, 39) == 0) ? 0 : 1,
                  ($urandom_range(0, 2) == 0) ? 1 : 0,
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1023)), lv);
            if (grant_obst && grant_green) chk("one_hot_grant", 2, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spawn_scheduler.md
# spawn_scheduler

Shares the single random-amplitude source and a spawn time slot between the obstacle controller and the collectible controller. Each requester pulses when its object leaves the screen and needs a new flight. The scheduler grants one spawn at a time, round-robin, and enforces a minimum gap of game ticks between spawns. It hands the granted controller a clamped arc amplitude and a flight speed derived from the current bank level. It sits between `random_generator`, `bank_control` and the two flight controllers.

## Interface
Parameters:
- `GAP_TICKS`, 8: minimum `game_en` ticks from one grant to the next arbitration.
- `AMP_MAX`, 10'd200: upper clamp on granted amplitude.
- `SPEED_BASE`, 10'd5: speed at bank level 0.
- `SPEED_MAX`, 10'd12: speed saturation value.
- `LEVEL_SHIFT`, 2: bank levels per speed step equal 2^LEVEL_SHIFT.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-low reset.
- `game_en`  in  1  one-cycle game tick strobe (already gated to the playing state).
- `enable`  in  1  high while the game is in the playing state.
- `req_obst`  in  1  one-cycle spawn request from the obstacle controller.
- `req_green`  in  1  one-cycle spawn request from the collectible controller.
- `rand_in`  in  10  current random amplitude.
- `bank_level`  in  8  current score.
- `grant_obst`  out  1  one-cycle grant pulse to the obstacle controller.
- `grant_green`  out  1  one-cycle grant pulse to the collectible controller.
- `spawn_amp`  out  10  amplitude for the granted spawn; held until the next grant.
- `spawn_speed`  out  10  speed for the granted spawn; held until the next grant.
- `busy`  out  1  high in the GRANT and GAP states.

## Operation
- Pending bits `pend_o` and `pend_g` are sticky.
  - A request pulse sets its bit.
  - A grant clears the bit.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Round-robin pointer `last` records the most recently granted requester. Its reset value is green, so the obstacle wins the first tie.
- States:
  - IDLE: on a cycle with `game_en`=1 and any pending bit set, select a winner and go to GRANT.
    - If exactly one bit is pending, that requester wins.
    - If both are pending, the requester that is not `last` wins.
  - GRANT (exactly one clk):
    - Pulse the winner's grant output.
    - Register `spawn_amp` = min(`rand_in`, `AMP_MAX`), using the value sampled in this cycle.
    - Register `spawn_speed` = min(`SPEED_BASE` + (`bank_level` >> `LEVEL_SHIFT`), `SPEED_MAX`). Compute the sum at 10 bits; it cannot overflow for 8-bit `bank_level`.
    - Clear the winner's pending bit and update `last`.
    - Load the gap counter with `GAP_TICKS`.
    - Go to GAP, or straight to IDLE if `GAP_TICKS`=0.
  - GAP: decrement the counter on each `game_en`. When the counter reaches 0, go to IDLE. Requests arriving during GAP are still latched.
- `enable`=0, checked with priority over all state logic:
  - State goes to IDLE, the gap counter clears and both pending bits clear. No grant is issued.
  - `spawn_amp`, `spawn_speed` and `last` keep their values.
  - Request pulses are ignored while `enable`=0.
- Only one grant is ever high in a given cycle. There are never two grants within `GAP_TICKS` game ticks of each other.

## Timing
- Reset values (async, `rst`=0):
  - `grant_obst` = 0, `grant_green` = 0.
  - `spawn_amp` = 0, `spawn_speed` = `SPEED_BASE`.
  - `busy` = 0.
  - State IDLE, pending bits 0, `last` = green, counter 0.
- Every output is registered. The grant pulse appears the cycle after the qualifying `game_en` cycle in IDLE. `spawn_amp` and `spawn_speed` become valid in the same cycle as the grant pulse.
- A request that arrives in the same cycle as a qualifying `game_en` tick is not seen until the next tick (pending is registered). Worst-case latency from request to grant is therefore (`GAP_TICKS` + 2) game ticks + 1 clk for a lone requester.
- `busy` rises with the grant pulse and falls in the cycle IDLE is re-entered.
- Deasserting reset mid-operation: the block resumes from reset values. No partial grant is emitted.

## Test plan
- Reset, `enable`=1, pulse `req_obst`, `rand_in`=150, `bank_level`=0 → on the next `game_en`: `grant_obst` for 1 clk, `spawn_amp`=150, `spawn_speed`=5, `busy`=1.
- Both requests pulsed together → grant obst first. After 8 more ticks, grant green. No grant is allowed inside the gap.
- `rand_in`=300, `bank_level`=12 → `spawn_amp`=200, `spawn_speed`=8. `bank_level`=255 → `spawn_speed`=12 (saturated).
- `req_green` pulsed in the same cycle as its own grant → pending remains set, and a second `grant_green` follows once the gap expires.
- `enable` dropped during GAP with `req_obst` pending → state IDLE, `busy`=0, pending cleared. After re-enable there is no grant until a new request arrives.
- `rst` asserted in the GRANT cycle → grants go 0 immediately and all outputs take their reset values.
